// File: rtl/lbp_gray_arbiter_if.sv
// Request/response and gray-memory bundle shared by the LBP engines and the gray read-port arbiter.
// slave is the arbiter side; master is the engines + memory side.
interface lbp_gray_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        eng_finish;
    logic                      gray_ready;
    logic                      gray_req;
    logic [ADDR_W-1:0]         gray_addr;
    logic [DATA_W-1:0]         gray_data;
    logic                      finish;

    modport master (
        output req_valid, req_addr, eng_finish, gray_ready, gray_data,
        input  req_ready, rsp_valid, rsp_data, gray_req, gray_addr, finish
    );

    modport slave (
        input  req_valid, req_addr, eng_finish, gray_ready, gray_data,
        output req_ready, rsp_valid, rsp_data, gray_req, gray_addr, finish
    );
endinterface

// File: rtl/lbp_gray_arbiter.sv
// Round-robin arbiter sharing one gray-image read port between NUM_REQ LBP engines.
// Define LBP_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module lbp_gray_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 0
) (
    input logic               clk,
    input logic               reset,
    lbp_gray_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned Depth = RD_LAT + 1;

    logic                  grant_vld;
    logic [PtrW-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ADDR_W-1:0]     grant_addr;

    logic                  gray_req_q, gray_req_d;
    logic [ADDR_W-1:0]     gray_addr_q, gray_addr_d;
    logic [Depth-1:0]      tag_vld_q, tag_vld_d;
    logic [Depth-1:0][PtrW-1:0] tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  finish_q, finish_d;

`ifndef LBP_ARB_FIXED_PRIO_EN
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    int                    cand;
`endif

    // Arbitration: descending scan so the last hit is the first candidate in priority order.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef LBP_ARB_FIXED_PRIO_EN
        if (bus.gray_ready) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (bus.req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = PtrW'(i);
                end
            end
        end
`else
        cand = 0;
        if (bus.gray_ready) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
                if (bus.req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = PtrW'(cand);
                end
            end
        end
`endif
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = grant_vld && (int'(grant_idx) == i);
        end
        grant_addr = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    end

    always_comb begin
        gray_req_d  = grant_vld;
        gray_addr_d = grant_vld ? grant_addr : gray_addr_q;
`ifndef LBP_ARB_FIXED_PRIO_EN
        rr_ptr_d    = grant_vld ? PtrW'((int'(grant_idx) + 1) % int'(NUM_REQ)) : rr_ptr_q;
`endif

        // Tag stage k lines up with the cycle RD_LAT-k before read data is valid.
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = grant_idx;
        for (int i = 1; i < Depth; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[Depth-1]) begin
            rsp_data_d = bus.gray_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (int'(tag_id_q[Depth-1]) == i);
            end
        end

        done_d   = done_q | bus.eng_finish;
        finish_d = finish_q || ((&done_q) && !(|tag_vld_q) && !gray_req_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            done_q      <= '0;
            finish_q    <= 1'b0;
`ifndef LBP_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            finish_q    <= finish_d;
`ifndef LBP_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.gray_req  = gray_req_q;
    assign bus.gray_addr = gray_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.finish    = finish_q;

endmodule
